div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 24 ++
 rtl/div_unit.sv | 144 ++++++++++++++
 tb/tb_div_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the 32-bit iterative divider: state encodings,
// handshake constants and a small sign helper.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // One restoring step per bit of quotient.
    localparam logic [5:0] DivSteps = 6'd32;

    function automatic logic [31:0] cond_negate(input logic [31:0] value, input logic neg);
        cond_negate = neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring shift-subtract divider for DIV/DIVU. Result is {remainder, quotient},
// ready 33 edges after accept (1 edge for a zero divisor).
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_t  state, state_next;
    logic [5:0]  cnt, cnt_next;
    logic [31:0] rem, rem_next;
    logic [31:0] quo, quo_next;
    logic [31:0] divisor, divisor_next;
    logic        neg_quo, neg_quo_next;
    logic        neg_rem, neg_rem_next;
    logic [63:0] result_next;
    logic        ready_next;

    logic [32:0] rem_shift;
    logic [33:0] diff;
    logic        op1_neg, op2_neg;

    // The dividend shifts out of quo into the partial remainder one bit per step.
    assign rem_shift = {rem, quo[31]};
    assign diff      = {1'b0, rem_shift} - {2'b00, divisor};
    assign op1_neg   = signed_div_i & opdata1_i[31];
    assign op2_neg   = signed_div_i & opdata2_i[31];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= 6'd0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            divisor  <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= DivResultNotReady;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            rem      <= rem_next;
            quo      <= quo_next;
            divisor  <= divisor_next;
            neg_quo  <= neg_quo_next;
            neg_rem  <= neg_rem_next;
            result_o <= result_next;
            ready_o  <= ready_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        rem_next     = rem;
        quo_next     = quo;
        divisor_next = divisor;
        neg_quo_next = neg_quo;
        neg_rem_next = neg_rem;
        result_next  = result_o;
        ready_next   = ready_o;

        unique case (state)
            DivFree: begin
                result_next = 64'd0;
                ready_next  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    // Work on magnitudes; signs are reapplied once the quotient is complete.
                    cnt_next     = 6'd0;
                    rem_next     = 32'd0;
                    quo_next     = cond_negate(opdata1_i, op1_neg);
                    divisor_next = cond_negate(opdata2_i, op2_neg);
                    neg_quo_next = op1_neg ^ op2_neg;
                    neg_rem_next = op1_neg;
                    if (opdata2_i == 32'd0) begin
                        state_next = DivByZero;
                    end else begin
                        state_next = DivOn;
                    end
                end
            end

            DivByZero: begin
                if (annul_i) begin
                    state_next  = DivFree;
                    result_next = 64'd0;
                    ready_next  = DivResultNotReady;
                end else begin
                    state_next  = DivEnd;
                    result_next = 64'd0;
                    ready_next  = DivResultReady;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_next  = DivFree;
                    cnt_next    = 6'd0;
                    result_next = 64'd0;
                    ready_next  = DivResultNotReady;
                end else if (cnt != DivSteps) begin
                    if (!diff[33]) begin
                        rem_next = diff[31:0];
                        quo_next = {quo[30:0], 1'b1};
                    end else begin
                        rem_next = rem_shift[31:0];
                        quo_next = {quo[30:0], 1'b0};
                    end
                    cnt_next = cnt + 6'd1;
                end else begin
                    state_next  = DivEnd;
                    cnt_next    = 6'd0;
                    result_next = {cond_negate(rem, neg_rem), cond_negate(quo, neg_quo)};
                    ready_next  = DivResultReady;
                end
            end

            DivEnd: begin
                // Hold the result until EX drops its request.
                if (start_i == DivStop) begin
                    state_next  = DivFree;
                    result_next = 64'd0;
                    ready_next  = DivResultNotReady;
                end
            end

            default: begin
                state_next  = DivFree;
                result_next = 64'd0;
                ready_next  = DivResultNotReady;
            end
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks;
    int fails;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating division as the ISA defines it, zero divisor gives zero.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // mode 0: plain request, 1: start dropped mid-run, 2: annul before E10, 3: reset before E20
    task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  input int mode, input string tag);
        int first;
        int lat_exp;
        int highs;
        logic [63:0] expect_val;
        expect_val = model(sgn, a, b);
        lat_exp    = (b == 32'd0) ? 1 : 33;
        first      = 0;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        signed_div_i = 1'($urandom);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        for (int k = 1; k <= 40; k++) begin
            if (mode == 1 && k == 5)  start_i = 1'b0;
            if (mode == 1 && k == 12) start_i = 1'b1;
            if (mode == 2 && k == 10) begin annul_i = 1'b1; start_i = 1'b0; end
            if (mode == 3 && k == 20) begin rst = 1'b1; start_i = 1'b0; end
            @(posedge clk);
            @(negedge clk);
            if ((mode == 2 && k == 10) || (mode == 3 && k == 20)) begin
                check_output({tag, " abort ready"}, {63'd0, ready_o}, 64'd0);
                check_output({tag, " abort result"}, result_o, 64'd0);
                annul_i = 1'b0;
                rst     = 1'b0;
                highs   = 0;
                for (int j = 0; j < 40; j++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (ready_o) highs++;
                end
                check_output({tag, " abort no result"}, 64'(highs), 64'd0);
                return;
            end
            if (ready_o) begin
                first = k;
                break;
            end
        end
        check_output({tag, " latency"}, 64'(first), 64'(lat_exp));
        check_output({tag, " result"}, result_o, expect_val);
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_output({tag, " hold"}, {ready_o, result_o[62:0]}, {1'b1, expect_val[62:0]});
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output({tag, " release"}, {ready_o, result_o[62:0]}, 64'd0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        checks       = 0;
        fails        = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset ready", {63'd0, ready_o}, 64'd0);
        check_output("reset result", result_o, 64'd0);
        rst = 1'b0;

        apply_stimulus(1'b0, 32'd100, 32'd7, 0, "divu 100/7");
        check_output("100/7 constant", model(1'b0, 32'd100, 32'd7), {32'h2, 32'hE});
        apply_stimulus(1'b1, 32'hFFFFFFF9, 32'd2, 0, "div -7/2");
        apply_stimulus(1'b0, 32'hFFFFFFFF, 32'd1, 0, "divu max/1");
        apply_stimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "div min/-1");
        apply_stimulus(1'b0, 32'd1234, 32'd0, 0, "divu by zero");
        apply_stimulus(1'b1, 32'h80000000, 32'd0, 0, "div by zero");
        apply_stimulus(1'b1, 32'd1000, 32'hFFFFFFFD, 1, "start dropped");
        apply_stimulus(1'b0, 32'd1000, 32'd3, 2, "annul 1000/3");
        apply_stimulus(1'b0, 32'd9, 32'd4, 0, "divu 9/4");
        apply_stimulus(1'b0, 32'd777, 32'd5, 3, "reset mid-run");
        apply_stimulus(1'b0, 32'd50, 32'd5, 0, "divu 50/5");

        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            apply_stimulus(sgn, a, b, 0, $sformatf("random %0d", i));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
